// File: rtl/rr_trace_packer.sv
// ----------------------------------------------------------------------------
// rr_trace_packer
//
// Record-side packer for the rr trace stream. Variable-length logging units
// (the low in_len bits of in_data) are concatenated LSB-first with no padding
// and cut into dense AXI_WIDTH-bit beats for the AXI storage writer. A
// single-cycle finish pulse drains any partial beat. The drained beat is
// zero-padded and tagged out_last, after which the block parks in DONE.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   in_valid/in_ready    unit handshake
//   in_data, in_len      unit payload and its length in bits (> WIDTH clamps)
//   finish               force-finish pulse (ignored outside RUN)
//   out_valid/out_ready  beat handshake
//   out_data, out_last   packed beat, final-beat marker
//   done                 high once the flush has completed
//   len_err              sticky flag: an accepted unit had in_len > WIDTH
//   record_bits          total payload bits accepted (wraps)
//   beat_cnt, stall_cnt  beat and back-pressure statistics
//
// Configuration:
//   RR_PACKER_STATS_EN   when defined, beat_cnt and stall_cnt are real
//                        counters. When undefined they read as zero and no
//                        counter flops are built.
// ----------------------------------------------------------------------------
module rr_trace_packer #(
    parameter int WIDTH        = 300,
    parameter int AXI_WIDTH    = 512,
    parameter int OFFSET_WIDTH = $clog2(WIDTH + 1),
    parameter int CNT_WIDTH    = 64
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [OFFSET_WIDTH-1:0] in_len,
    input  logic                    finish,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [AXI_WIDTH-1:0]    out_data,
    output logic                    out_last,
    output logic                    done,
    output logic                    len_err,
    output logic [CNT_WIDTH-1:0]    record_bits,
    output logic [CNT_WIDTH-1:0]    beat_cnt,
    output logic [CNT_WIDTH-1:0]    stall_cnt
);

    localparam int ACC_W  = 2 * AXI_WIDTH;
    localparam int FILL_W = $clog2(2 * AXI_WIDTH + 1);

    localparam logic [FILL_W-1:0]       AXI_FILL = FILL_W'(AXI_WIDTH);
    localparam logic [OFFSET_WIDTH-1:0] MAX_LEN  = OFFSET_WIDTH'(WIDTH);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic                 len_err_q, len_err_d;
    logic [CNT_WIDTH-1:0] record_bits_q, record_bits_d;

    logic                    out_fire;
    logic                    in_fire;
    logic                    len_over;
    logic [OFFSET_WIDTH-1:0] eff_len;
    logic [WIDTH-1:0]        unit_mask;
    logic [WIDTH-1:0]        unit_bits;
    logic [AXI_WIDTH-1:0]    keep_mask;
    logic [ACC_W-1:0]        acc_shift;
    logic [FILL_W-1:0]       fill_shift;

    // Handshake outputs and the beat view, decoded from the current state.
    // In FLUSH the beat is masked down to the valid bits so a short final
    // beat is always zero-padded.
    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        in_ready  = 1'b0;
        done      = 1'b0;
        keep_mask = '1;
        case (state_q)
            ST_RUN: begin
                out_valid = (fill_q >= AXI_FILL);
                in_ready  = (fill_q < AXI_FILL) || ((fill_q >= AXI_FILL) && out_ready);
            end
            ST_FLUSH: begin
                out_valid = (fill_q != '0);
                out_last  = (fill_q != '0) && (fill_q <= AXI_FILL);
                if (fill_q < AXI_FILL) begin
                    keep_mask = ~({AXI_WIDTH{1'b1}} << fill_q);
                end
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
        out_data = acc_q[AXI_WIDTH-1:0] & keep_mask;
    end

    // Accumulator datapath. When a beat leaves and a unit arrives in the same
    // cycle the shift is applied first, so the unit lands at the post-shift
    // fill. Bits above fill are kept zero, which lets the insert be a plain OR.
    always_comb begin
        out_fire   = out_valid && out_ready;
        in_fire    = in_valid && in_ready;
        len_over   = (in_len > MAX_LEN);
        eff_len    = len_over ? MAX_LEN : in_len;
        unit_mask  = {WIDTH{1'b1}} >> (MAX_LEN - eff_len);
        unit_bits  = in_data & unit_mask;

        acc_shift  = acc_q;
        fill_shift = fill_q;
        if (out_fire) begin
            acc_shift  = acc_q >> AXI_WIDTH;
            fill_shift = (fill_q > AXI_FILL) ? (fill_q - AXI_FILL) : '0;
        end

        acc_d         = acc_shift;
        fill_d        = fill_shift;
        len_err_d     = len_err_q;
        record_bits_d = record_bits_q;
        if (in_fire) begin
            acc_d         = acc_shift | (ACC_W'(unit_bits) << fill_shift);
            fill_d        = fill_shift + FILL_W'(eff_len);
            len_err_d     = len_err_q | len_over;
            record_bits_d = record_bits_q + CNT_WIDTH'(eff_len);
        end
    end

    // Next-state logic. A finish with nothing buffered (after this cycle's
    // accept) skips FLUSH entirely so an empty trace produces no beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (finish) begin
                    state_d = (fill_d == '0) ? ST_DONE : ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (fill_q == '0) begin
                    state_d = ST_DONE;
                end else if (out_fire && out_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_RUN;
            acc_q         <= '0;
            fill_q        <= '0;
            len_err_q     <= 1'b0;
            record_bits_q <= '0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            fill_q        <= fill_d;
            len_err_q     <= len_err_d;
            record_bits_q <= record_bits_d;
        end
    end

    assign len_err     = len_err_q;
    assign record_bits = record_bits_q;

`ifdef RR_PACKER_STATS_EN
    logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    // Statistics: one count per emitted beat, one per back-pressured cycle.
    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (out_fire) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end
        if (out_valid && !out_ready) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign beat_cnt  = beat_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign beat_cnt  = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_rr_trace_packer.sv
// ----------------------------------------------------------------------------
// tb_rr_trace_packer
//
// Self-checking bench for rr_trace_packer with AXI_WIDTH=256, WIDTH=128.
// A vector table covers dense packing and beat-boundary splitting, followed
// by hand-written sequences for back-pressure, flush, empty finish, length
// clamping and asynchronous reset mid-beat.
// ----------------------------------------------------------------------------
module tb_rr_trace_packer;

    localparam int W  = 128;
    localparam int AW = 256;
    localparam int OW = $clog2(W + 1);
    localparam int CW = 64;

`ifdef RR_PACKER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk;
    logic          rstn;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [OW-1:0] in_len;
    logic          finish;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_data;
    logic          out_last;
    logic          done;
    logic          len_err;
    logic [CW-1:0] record_bits;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] stall_cnt;

    rr_trace_packer #(
        .WIDTH(W),
        .AXI_WIDTH(AW),
        .OFFSET_WIDTH(OW),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_len(in_len),
        .finish(finish),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .done(done),
        .len_err(len_err),
        .record_bits(record_bits),
        .beat_cnt(beat_cnt),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          iv;
        logic [W-1:0]  d;
        logic [OW-1:0] len;
        logic          fin;
        logic          ordy;
        logic          e_ir;
        logic          e_ov;
        logic [AW-1:0] e_data;
        logic          e_last;
        logic          e_done;
        logic [CW-1:0] e_rb;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mkVec(input logic iv, input logic [W-1:0] d,
                                   input logic [OW-1:0] len, input logic fin,
                                   input logic ordy, input logic e_ir,
                                   input logic e_ov, input logic [AW-1:0] e_data,
                                   input logic e_last, input logic e_done,
                                   input logic [CW-1:0] e_rb);
        vec_t v;
        v.iv = iv; v.d = d; v.len = len; v.fin = fin; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_data = e_data; v.e_last = e_last;
        v.e_done = e_done; v.e_rb = e_rb;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [AW-1:0] act,
                               input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkCore(input string tag, input logic e_ir, input logic e_ov,
                             input logic e_last, input logic e_done);
        checkOutput({tag, " in_ready"}, AW'(in_ready), AW'(e_ir));
        checkOutput({tag, " out_valid"}, AW'(out_valid), AW'(e_ov));
        if (e_ov) begin
            checkOutput({tag, " out_last"}, AW'(out_last), AW'(e_last));
        end
        checkOutput({tag, " done"}, AW'(done), AW'(e_done));
    endtask

    // Drive one cycle of inputs just after the falling edge and let them settle.
    task automatic applyStimulus(input logic iv, input logic [W-1:0] d,
                                 input logic [OW-1:0] len, input logic fin,
                                 input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        in_len    = len;
        finish    = fin;
        out_ready = ordy;
        #1;
    endtask

    task automatic doReset(input string tag);
        @(negedge clk);
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_len    = '0;
        finish    = 1'b0;
        out_ready = 1'b0;
        #2;
        checkCore({tag, " reset"}, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput({tag, " reset len_err"}, AW'(len_err), '0);
        checkOutput({tag, " reset record_bits"}, AW'(record_bits), '0);
        checkOutput({tag, " reset beat_cnt"}, AW'(beat_cnt), '0);
        checkOutput({tag, " reset stall_cnt"}, AW'(stall_cnt), '0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        logic [W-1:0]  a, b, c, x, y, z, d40, ones;
        logic [AW-1:0] beat0, tail, exp_d;

        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_len    = '0;
        finish    = 1'b0;
        out_ready = 1'b0;

        a    = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98;
        b    = 128'h1357_9BDF_2468_ACE0_0F1E_2D3C_4B5A_6978;
        c    = 128'hCAFE_F00D_1122_3344_5566_7788_99AA_BBCC;
        beat0 = {c[55:0], b[99:0], a[99:0]};
        tail  = {212'b0, c[99:56]};

        // Four 64-bit units make exactly one beat; then three 100-bit units
        // straddle a beat boundary and the 44-bit remainder is flushed.
        vecs[0]  = mkVec(1, 128'h1, 64, 0, 1, 1, 0, '0, 0, 0, 0);
        vecs[1]  = mkVec(1, 128'h2, 64, 0, 1, 1, 0, '0, 0, 0, 64);
        vecs[2]  = mkVec(1, 128'h3, 64, 0, 1, 1, 0, '0, 0, 0, 128);
        vecs[3]  = mkVec(1, 128'h4, 64, 0, 1, 1, 0, '0, 0, 0, 192);
        vecs[4]  = mkVec(0, '0, 0, 0, 1, 1, 1, {64'h4, 64'h3, 64'h2, 64'h1}, 0, 0, 256);
        vecs[5]  = mkVec(0, '0, 0, 0, 1, 1, 0, '0, 0, 0, 256);
        vecs[6]  = mkVec(1, a, 100, 0, 1, 1, 0, '0, 0, 0, 256);
        vecs[7]  = mkVec(1, b, 100, 0, 1, 1, 0, '0, 0, 0, 356);
        vecs[8]  = mkVec(1, c, 100, 0, 1, 1, 0, '0, 0, 0, 456);
        vecs[9]  = mkVec(0, '0, 0, 0, 1, 1, 1, beat0, 0, 0, 556);
        vecs[10] = mkVec(0, '0, 0, 1, 1, 1, 0, '0, 0, 0, 556);
        vecs[11] = mkVec(0, '0, 0, 0, 1, 0, 1, tail, 1, 0, 556);
        vecs[12] = mkVec(0, '0, 0, 0, 1, 0, 0, '0, 0, 1, 556);
        vecs[13] = mkVec(0, '0, 0, 1, 1, 0, 0, '0, 0, 1, 556);
        vecs[14] = mkVec(0, '0, 0, 0, 1, 0, 0, '0, 0, 1, 556);

        doReset("init");

        for (int i = 0; i < 15; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            applyStimulus(vecs[i].iv, vecs[i].d, vecs[i].len, vecs[i].fin, vecs[i].ordy);
            checkCore(tag, vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_last, vecs[i].e_done);
            if (vecs[i].e_ov) begin
                checkOutput({tag, " out_data"}, out_data, vecs[i].e_data);
            end
            checkOutput({tag, " record_bits"}, AW'(record_bits), AW'(vecs[i].e_rb));
            checkOutput({tag, " len_err"}, AW'(len_err), '0);
        end

        // Back-pressure: two full units fill a beat, the third waits until
        // out_ready returns and is accepted in the same cycle the beat leaves.
        doReset("stall");
        x = 128'h0F0F_0F0F_1111_2222_3333_4444_5555_6666;
        y = 128'hF0F0_F0F0_7777_8888_9999_AAAA_BBBB_CCCC;
        z = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        applyStimulus(1, x, 128, 0, 0);
        checkCore("stall s0", 1, 0, 0, 0);
        applyStimulus(1, y, 128, 0, 0);
        checkCore("stall s1", 1, 0, 0, 0);
        applyStimulus(1, z, 128, 0, 0);
        checkCore("stall s2", 0, 1, 0, 0);
        checkOutput("stall s2 out_data", out_data, {y, x});
        applyStimulus(1, z, 128, 0, 0);
        checkCore("stall s3", 0, 1, 0, 0);
        checkOutput("stall s3 out_data held", out_data, {y, x});
        applyStimulus(1, z, 128, 0, 1);
        checkCore("stall s4", 1, 1, 0, 0);
        checkOutput("stall s4 out_data", out_data, {y, x});
        checkOutput("stall s4 stall_cnt", AW'(stall_cnt), STATS ? AW'(2) : '0);
        applyStimulus(0, '0, 0, 0, 1);
        checkCore("stall s5", 1, 0, 0, 0);
        checkOutput("stall s5 record_bits", AW'(record_bits), AW'(384));
        checkOutput("stall s5 beat_cnt", AW'(beat_cnt), STATS ? AW'(1) : '0);
        applyStimulus(0, '0, 0, 1, 1);
        checkCore("stall s6", 1, 0, 0, 0);
        applyStimulus(0, '0, 0, 0, 1);
        checkCore("stall s7", 0, 1, 1, 0);
        checkOutput("stall s7 out_data", out_data, {128'b0, z});
        applyStimulus(0, '0, 0, 0, 1);
        checkCore("stall s8", 0, 0, 0, 1);
        checkOutput("stall s8 beat_cnt", AW'(beat_cnt), STATS ? AW'(2) : '0);
        checkOutput("stall s8 stall_cnt", AW'(stall_cnt), STATS ? AW'(2) : '0);

        // Short trace: one 40-bit unit with junk above bit 40, then finish.
        doReset("flush40");
        d40 = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFA5_5A12_3456;
        exp_d = '0;
        exp_d[39:0] = d40[39:0];
        applyStimulus(1, d40, 40, 0, 1);
        checkCore("flush40 r0", 1, 0, 0, 0);
        applyStimulus(0, '0, 0, 1, 1);
        checkCore("flush40 r1", 1, 0, 0, 0);
        applyStimulus(0, '0, 0, 0, 1);
        checkCore("flush40 r2", 0, 1, 1, 0);
        checkOutput("flush40 r2 out_data", out_data, exp_d);
        applyStimulus(0, '0, 0, 1, 1);
        checkCore("flush40 r3", 0, 0, 0, 1);
        applyStimulus(0, '0, 0, 0, 1);
        checkCore("flush40 r4", 0, 0, 0, 1);
        checkOutput("flush40 r4 record_bits", AW'(record_bits), AW'(40));

        // Empty trace: finish with nothing buffered goes straight to done.
        doReset("empty");
        applyStimulus(0, '0, 0, 1, 1);
        checkCore("empty e0", 1, 0, 0, 0);
        applyStimulus(0, '0, 0, 0, 1);
        checkCore("empty e1", 0, 0, 0, 1);
        applyStimulus(0, '0, 0, 0, 1);
        checkCore("empty e2", 0, 0, 0, 1);

        // Over-long unit is clamped to 128 bits and flagged; an async reset
        // while a beat is stalled discards everything without a clock edge.
        doReset("lenerr");
        ones = '1;
        applyStimulus(1, ones, 200, 0, 0);
        checkCore("lenerr l0", 1, 0, 0, 0);
        checkOutput("lenerr l0 len_err", AW'(len_err), '0);
        applyStimulus(1, '0, 128, 0, 0);
        checkCore("lenerr l1", 1, 0, 0, 0);
        checkOutput("lenerr l1 len_err", AW'(len_err), AW'(1));
        checkOutput("lenerr l1 record_bits", AW'(record_bits), AW'(128));
        applyStimulus(0, '0, 0, 0, 0);
        checkCore("lenerr l2", 0, 1, 0, 0);
        checkOutput("lenerr l2 out_data", out_data, {128'b0, ones});
        checkOutput("lenerr l2 record_bits", AW'(record_bits), AW'(256));
        #1;
        rstn = 1'b0;
        #1;
        checkCore("async", 1, 0, 0, 0);
        checkOutput("async len_err", AW'(len_err), '0);
        checkOutput("async record_bits", AW'(record_bits), '0);
        checkOutput("async beat_cnt", AW'(beat_cnt), '0);
        checkOutput("async stall_cnt", AW'(stall_cnt), '0);
        @(negedge clk);
        rstn = 1'b1;
        applyStimulus(0, '0, 0, 1, 1);
        checkCore("async a0", 1, 0, 0, 0);
        applyStimulus(0, '0, 0, 0, 1);
        checkCore("async a1", 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_trace_packer.md
Name: rr_trace_packer

Overview:
- Record-side packer that turns the variable-length logging units of an rr_stream_bus_t into dense, fixed-width beats for the AXI storage writer.
- Each unit is the low in_len bits of in_data. Units are concatenated LSB-first with no padding and split across beat boundaries.
- A force-finish request drains any partial beat, zero-padded and tagged last.
- Replaces the fixed 512-bit packing inside the trace writer. Beat width, unit width and counter width are all parameters.
- Adds length-error detection and a bit counter.

Parameters:
- WIDTH, 300, max logging unit width in bits; must be <= AXI_WIDTH.
- AXI_WIDTH, 512, output beat width in bits.
- OFFSET_WIDTH, $clog2(WIDTH+1), width of in_len.
- CNT_WIDTH, 64, width of the statistics counters.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- in_valid  input  1  unit valid
- in_ready  output  1  unit accepted when in_valid && in_ready
- in_data  input  WIDTH  unit payload; bits >= in_len are ignored
- in_len  input  OFFSET_WIDTH  unit length in bits
- finish  input  1  single-cycle force-finish pulse
- out_valid  output  1  beat valid
- out_ready  input  1  downstream ready
- out_data  output  AXI_WIDTH  packed beat
- out_last  output  1  final beat of a finished trace
- done  output  1  high after the flush completes
- len_err  output  1  sticky: an in_len > WIDTH was seen
- record_bits  output  CNT_WIDTH  total payload bits accepted
- beat_cnt  output  CNT_WIDTH  beats emitted (see Optional Feature)
- stall_cnt  output  CNT_WIDTH  cycles with out_valid && !out_ready (see Optional Feature)

Behaviour:
- Storage and fill:
  - Accumulator acc[2*AXI_WIDTH-1:0] holds valid bits in [fill-1:0].
  - fill is a $clog2(2*AXI_WIDTH+1)-bit count of valid bits.
- Reset (async, rstn=0): state=RUN, acc=0, fill=0.
  - Outputs: out_valid=0, out_last=0, done=0, len_err=0, all counters 0.
  - in_ready follows combinationally from the reset state (1 in RUN with fill=0).
- Outputs in RUN:
  - out_valid = (fill >= AXI_WIDTH). out_data = acc[AXI_WIDTH-1:0]. out_last=0.
- Accept rule in RUN:
  - in_ready = (fill < AXI_WIDTH) || (out_valid && out_ready).
  - The second term is combinational from out_ready and gives full throughput.
- Per-cycle update in RUN (effective len L = min(in_len, WIDTH)):
  - Output fire: acc >>= AXI_WIDTH, fill -= AXI_WIDTH.
  - Input fire: write in_data[L-1:0] at bit position fill (post-shift fill when both fire in the same cycle), then fill += L.
  - Both fire in one cycle: the shift happens first, then the insert.
- Length handling:
  - L=0 is accepted as a no-op.
  - in_len > WIDTH sets len_err and is clamped to WIDTH.
- record_bits += L on each accept. Wrap at 2^CNT_WIDTH is allowed.
- Latency: a unit that completes a beat makes out_valid high on the next clock edge.
- State machine:
  - RUN -> FLUSH on finish=1. A unit accepted in the same cycle is included.
  - FLUSH:
    - in_ready=0.
    - out_valid = (fill > 0).
    - out_data = acc[AXI_WIDTH-1:0] with bits >= fill zeroed.
    - out_last = (fill <= AXI_WIDTH).
    - On fire: shift as in RUN; fill = max(fill - AXI_WIDTH, 0).
  - FLUSH -> DONE when the out_last beat fires, or immediately if fill=0 on entry. An empty trace emits no beat.
  - DONE: done=1, in_ready=0, out_valid=0. A further finish is ignored. Only reset leaves DONE.
  - finish while in FLUSH is ignored.
- Handshake rules:
  - out_data and out_last are held stable while out_valid && !out_ready.
  - out_valid never drops without a handshake, except on reset.
- Reset mid-operation: all buffered data is discarded, with no beat emitted.

Optional Feature:
- Macro: RR_PACKER_STATS_EN.
- Defined:
  - beat_cnt increments on each out fire.
  - stall_cnt increments each cycle with out_valid && !out_ready.
  - Both reset to 0.
- Undefined:
  - beat_cnt and stall_cnt are tied to 0 and the counter flops are not built.
  - All other behaviour is identical.

Test Plan (AXI_WIDTH=256, WIDTH=128):
- Four units of len 64, values 1..4, out_ready=1 -> one beat {64'h4,64'h3,64'h2,64'h1} on the cycle after the 4th accept; record_bits=256; in_ready stays 1.
- Three units of len 100 (A, B, C), out_ready=1 -> beat0 = {C[55:0],B,A}; fill=44 holding C[99:56].
- out_ready=0 with 3x128-bit units -> 2 accepted, then in_ready=0 and out_data stable; stall_cnt counts under RR_PACKER_STATS_EN. Release out_ready -> beat fires, 3rd unit accepted the same cycle.
- One unit of len 40, then finish -> one beat: bits [39:0]=data, [255:40]=0, out_last=1; done=1 next cycle. A 2nd finish causes no change.
- finish with fill=0 -> no beat, done=1 one cycle later.
- in_len=200 -> len_err=1 and 128 bits packed. Assert rstn=0 mid-beat -> out_valid=0, fill=0, len_err=0 and counters=0 immediately, with no clock needed.
